base_tiempo_rampa: RTL

Parametrised step-rate time base for the motor driver. It generates a square-wave speed clock `vel` and a one-cycle `step` pulse. The rate is one of NVEL binary-divided speeds. Speed changes are ramped one level at a time, on half-period boundaries, so the motor never sees an abrupt rate jump. It sits between the user speed selector and the stepper phase sequencer.

---
 rtl/base_tiempo_rampa.sv | 65 ++++++
 1 files changed

// File: rtl/base_tiempo_rampa.sv
// Step-rate time base: square-wave speed clock `vel` plus a one-clock `step`
// pulse, with speed changes ramped one level at a time on half-period boundaries.
module base_tiempo_rampa #(
    parameter int unsigned F_CLK     = 50000000,
    parameter int unsigned NVEL      = 8,
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned CNT_W     = 26,
    parameter int unsigned RAMP_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] select,
    output logic             vel,
    output logic             step,
    output logic [SEL_W-1:0] cur_vel,
    output logic             busy
);

    localparam int unsigned     HOLD_W    = (RAMP_HOLD > 1) ? $clog2(RAMP_HOLD) : 1;
    localparam logic [SEL_W:0]  NVEL_EXT  = (SEL_W+1)'(NVEL);
    localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(NVEL - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RAMP_HOLD - 1);

    // Terminal count of level k: H_k - 1, a constant per level.
    function automatic logic [CNT_W-1:0] half_m1(input logic [SEL_W-1:0] k);
        return CNT_W'((F_CLK >> k) - 1);
    endfunction

    logic [SEL_W-1:0]  target;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold;
    logic              toggle;

    assign target = ({1'b0, select} >= NVEL_EXT) ? MAX_SEL : select;
    assign toggle = (cnt == half_m1(cur_vel));
    assign busy   = en & (cur_vel != target);

    // Disabled behaves exactly like reset so a restart always ramps from level 0.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt     <= '0;
            hold    <= '0;
            vel     <= 1'b0;
            step    <= 1'b0;
            cur_vel <= '0;
        end else if (toggle) begin
            cnt  <= '0;
            vel  <= ~vel;
            step <= ~vel;
            if (cur_vel == target) begin
                hold <= '0;
            end else if (hold == HOLD_LAST) begin
                hold    <= '0;
                cur_vel <= (target > cur_vel) ? cur_vel + SEL_W'(1) : cur_vel - SEL_W'(1);
            end else begin
                hold <= hold + HOLD_W'(1);
            end
        end else begin
            cnt  <= cnt + CNT_W'(1);
            step <= 1'b0;
        end
    end

endmodule
